// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline control unit for the 5-stage CPU. It merges per-source stall
//   requests into a per-stage hold vector, sequences redirect/exception
//   flushes with a req/ack handshake, and watches for stalls that run too long.
//
// Ports
//   clk            in   1       clock, rising edge
//   rst            in   1       synchronous, active-high reset
//   stall_req      in   NREQ    level stall request per source
//   redir_req      in   1       redirect request, held until redir_ack
//   redir_pc       in   32      redirect target, valid with redir_req
//   redir_ack      out  1       one-cycle accept pulse (coincides with flush)
//   flush          out  1       kill all in-flight stages this cycle
//   new_pc         out  32      PC to load while flush=1
//   stall          out  NSTAGE  per-stage hold (combinational, zero latency)
//   stall_cnt      out  8       consecutive stalled cycles, saturating
//   stall_timeout  out  1       sticky watchdog flag
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned         NSTAGE    = 6,
    parameter int unsigned         NREQ      = 4,
    parameter logic [3*NREQ-1:0]   REQ_STAGE = {3'd4, 3'd3, 3'd3, 3'd2},
    parameter int unsigned         HOLD_CYC  = 2,
    parameter int unsigned         WDOG_LIM  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              redir_req,
    input  logic [31:0]       redir_pc,
    output logic              redir_ack,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic [NSTAGE-1:0] stall,
    output logic [7:0]        stall_cnt,
    output logic              stall_timeout
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_ack;
    logic                r_flush;
    logic [31:0]         r_new_pc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout;

    logic [NSTAGE-1:0]   w_stall_merge;
    logic [NSTAGE-1:0]   w_stall;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Stall merge: a request at stage k freezes stage k and everything upstream.
    always_comb begin
        w_stall_merge = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (stall_req[i]) begin
                for (int unsigned s = 0; s < NSTAGE; s++) begin
                    if (s <= 32'(REQ_STAGE[3*i +: 3])) begin
                        w_stall_merge[s] = 1'b1;
                    end
                end
            end
        end
    end

    // A flushed pipeline has nothing worth holding, so stall is dropped in FLUSH.
    assign w_stall = (rst || (r_state == S_FLUSH)) ? '0 : w_stall_merge;

    // Redirect sequencing: RUN accepts, FLUSH lasts one cycle, HOLD blocks re-entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_hold   <= '0;
            r_ack    <= 1'b0;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (redir_req) begin
                        r_state  <= S_FLUSH;
                        r_new_pc <= redir_pc;
                        r_ack    <= 1'b1;
                        r_flush  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_HOLD;
                    r_hold  <= HOLD_W'(HOLD_CYC - 1);
                    r_ack   <= 1'b0;
                    r_flush <= 1'b0;
                end
                S_HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_ack   <= 1'b0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog count of consecutive stalled cycles, saturating at all-ones.
    always_comb begin
        w_cnt_nxt = '0;
        if (w_stall != '0) begin
            w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    // Timeout rises on the same edge the count reaches the limit, then sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (32'(w_cnt_nxt) == WDOG_LIM) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall         = w_stall;
    assign redir_ack     = r_ack;
    assign flush         = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_cnt     = r_cnt;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl: a stall-merge vector table plus
//   hand-written sequences for redirect, hold spacing, reset during flush
//   and the stall watchdog. Inputs change 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  stall_req;
    logic        redir_req;
    logic [31:0] redir_pc;
    logic        redir_ack;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic [7:0]  stall_cnt;
    logic        stall_timeout;

    int n_pass;
    int n_total;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .redir_req     (redir_req),
        .redir_pc      (redir_pc),
        .redir_ack     (redir_ack),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall         (stall),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int first_ack;
        int second_ack;
        int exp_cnt;

        n_pass  = 0;
        n_total = 0;

        // src0=ID(2), src1=EX(3), src2=EX(3), src3=MEM(4)
        vecs[0] = '{4'b0000, 6'b000000};
        vecs[1] = '{4'b0001, 6'b000111};
        vecs[2] = '{4'b0010, 6'b001111};
        vecs[3] = '{4'b0100, 6'b001111};
        vecs[4] = '{4'b1000, 6'b011111};
        vecs[5] = '{4'b1010, 6'b011111};
        vecs[6] = '{4'b0011, 6'b001111};
        vecs[7] = '{4'b0101, 6'b001111};
        vecs[8] = '{4'b1111, 6'b011111};
        vecs[9] = '{4'b0000, 6'b000000};

        // Reset with every stall source active
        rst       = 1'b1;
        stall_req = 4'b1111;
        redir_req = 1'b0;
        redir_pc  = 32'h0;
        tick();
        tick();
        chk("rst_stall",   32'(stall), 32'h0);
        chk("rst_flush",   32'(flush), 32'h0);
        chk("rst_ack",     32'(redir_ack), 32'h0);
        chk("rst_new_pc",  new_pc, 32'h0);
        chk("rst_cnt",     32'(stall_cnt), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        rst       = 1'b0;
        stall_req = 4'b0000;

        // Stall merge table
        for (int i = 0; i < 10; i++) begin
            tick();
            stall_req = vecs[i].req;
            #1;
            chk($sformatf("merge_%0d", i), 32'(stall), 32'(vecs[i].exp_stall));
        end

        // Redirect together with an ID stall request
        tick();
        stall_req = 4'b0001;
        redir_req = 1'b1;
        redir_pc  = 32'hBFC0_0380;
        #1;
        chk("cap_stall", 32'(stall), 32'(6'b000111));
        chk("cap_flush", 32'(flush), 32'h0);
        tick();
        chk("fl_flush",  32'(flush), 32'h1);
        chk("fl_ack",    32'(redir_ack), 32'h1);
        chk("fl_new_pc", new_pc, 32'hBFC0_0380);
        chk("fl_stall",  32'(stall), 32'h0);
        redir_req = 1'b0;
        redir_pc  = 32'h0;
        tick();
        chk("post_flush",  32'(flush), 32'h0);
        chk("post_ack",    32'(redir_ack), 32'h0);
        chk("hold_stall",  32'(stall), 32'(6'b000111));
        chk("hold_new_pc", new_pc, 32'hBFC0_0380);
        stall_req = 4'b0000;
        repeat (4) tick();

        // Redirect held through HOLD: acks exactly four cycles apart
        redir_req  = 1'b1;
        redir_pc   = 32'h0000_1000;
        first_ack  = -1;
        second_ack = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (redir_ack) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
        end
        redir_req = 1'b0;
        chk("held_first_ack", 32'(first_ack), 32'd1);
        chk("held_ack_gap",   32'(second_ack - first_ack), 32'd4);
        repeat (4) tick();

        // Reset asserted during FLUSH abandons it
        redir_req = 1'b1;
        redir_pc  = 32'h1234_5678;
        tick();
        chk("rf_flush_in", 32'(flush), 32'h1);
        rst       = 1'b1;
        redir_req = 1'b0;
        stall_req = 4'b1000;
        tick();
        chk("rf_flush", 32'(flush), 32'h0);
        chk("rf_ack",   32'(redir_ack), 32'h0);
        chk("rf_stall", 32'(stall), 32'h0);
        rst       = 1'b0;
        stall_req = 4'b0000;
        redir_req = 1'b1;
        redir_pc  = 32'hCAFE_0004;
        tick();
        chk("rf_again_flush", 32'(flush), 32'h1);
        chk("rf_again_ack",   32'(redir_ack), 32'h1);
        chk("rf_again_pc",    new_pc, 32'hCAFE_0004);
        redir_req = 1'b0;
        repeat (4) tick();

        // Watchdog: MEM stall held 300 cycles
        chk("wd_cnt_start", 32'(stall_cnt), 32'h0);
        stall_req = 4'b1000;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 1 || k == 128 || k == 254 || k == 255 || k == 256 || k == 300) begin
                exp_cnt = (k > 255) ? 255 : k;
                chk($sformatf("wd_cnt_%0d", k), 32'(stall_cnt), 32'(exp_cnt));
                chk($sformatf("wd_to_%0d", k), 32'(stall_timeout), (k >= 255) ? 32'h1 : 32'h0);
            end
        end
        stall_req = 4'b0000;
        #1;
        chk("wd_rel_stall", 32'(stall), 32'h0);
        tick();
        chk("wd_rel_cnt", 32'(stall_cnt), 32'h0);
        chk("wd_rel_to",  32'(stall_timeout), 32'h1);
        tick();
        chk("wd_sticky",  32'(stall_timeout), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
